// File: rtl/meter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : meter_bank
//  Purpose  : Bank of N_CH countdown meters (e.g. parking-meter channels).
//             Commands add fixed amounts with saturation, load presets or
//             clear a channel.  Each 1 Hz tick starts a sweep that
//             decrements every nonzero channel by one, one channel per
//             clock cycle.  Commands are refused (cmd_ready=0) while a
//             sweep is running.
//  Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//             tick_1hz        - one-cycle pulse per second
//             cmd_valid/ready - command handshake
//             cmd_op, cmd_ch  - opcode and target channel
//             disp_ch         - channel shown on disp_time (registered)
//             expired         - per-channel time==0
//             low_warn        - per-channel 0 < time <= WARN
//             tick_ovf        - one-cycle pulse when a tick is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module meter_bank #(
    parameter int N_CH  = 4,
    parameter int TW    = 14,
    parameter int T_MAX = 9999,
    parameter int AMT0  = 10,
    parameter int AMT1  = 180,
    parameter int AMT2  = 200,
    parameter int AMT3  = 550,
    parameter int LD0   = 10,
    parameter int LD1   = 205,
    parameter int WARN  = 10,
    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_1hz,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [CW-1:0] cmd_ch,
    input  logic [CW-1:0] disp_ch,
    output logic [TW-1:0] disp_time,
    output logic [N_CH-1:0] expired,
    output logic [N_CH-1:0] low_warn,
    output logic          tick_ovf
);

    localparam logic [TW:0]   c_t_max_w = (TW+1)'(T_MAX);
    localparam logic [TW-1:0] c_t_max   = TW'(T_MAX);
    localparam logic [TW-1:0] c_warn    = TW'(WARN);
    // Presets are clamped so a load can never break the ceiling invariant.
    localparam logic [TW-1:0] c_ld0     = (LD0 > T_MAX) ? TW'(T_MAX) : TW'(LD0);
    localparam logic [TW-1:0] c_ld1     = (LD1 > T_MAX) ? TW'(T_MAX) : TW'(LD1);
    localparam logic [TW:0]   c_amt0    = (TW+1)'(AMT0);
    localparam logic [TW:0]   c_amt1    = (TW+1)'(AMT1);
    localparam logic [TW:0]   c_amt2    = (TW+1)'(AMT2);
    localparam logic [TW:0]   c_amt3    = (TW+1)'(AMT3);
    localparam logic [CW-1:0] c_last    = CW'(N_CH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          tick_pend_q, tick_pend_d;
    logic          tick_ovf_q, tick_ovf_d;
    logic [TW-1:0] disp_time_q, disp_time_d;
    logic [TW-1:0] time_q [N_CH];
    logic [TW-1:0] time_d [N_CH];

    logic          w_cmd_hit;
    logic [TW-1:0] w_cur;
    logic [TW:0]   w_amt;
    logic [TW:0]   w_sum;

    assign cmd_ready = (state_q == ST_IDLE);
    assign disp_time = disp_time_q;
    assign tick_ovf  = tick_ovf_q;

    // Out-of-range channel numbers handshake normally but touch nothing.
    assign w_cmd_hit = cmd_valid && cmd_ready &&
                       ({{(32-CW){1'b0}}, cmd_ch} < 32'(N_CH));
    assign w_cur     = time_q[cmd_ch];

    always_comb begin
        w_amt = c_amt0;
        case (cmd_op[1:0])
            2'd0:    w_amt = c_amt0;
            2'd1:    w_amt = c_amt1;
            2'd2:    w_amt = c_amt2;
            default: w_amt = c_amt3;
        endcase
    end

    // One extra bit keeps the carry so saturation is a simple compare.
    assign w_sum = {1'b0, w_cur} + w_amt;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tick_pend_d = tick_pend_q;
        tick_ovf_d  = 1'b0;
        time_d      = time_q;

        case (state_q)
            ST_IDLE: begin
                if (tick_1hz || tick_pend_q) begin
                    state_d     = ST_SWEEP;
                    idx_d       = '0;
                    tick_pend_d = 1'b0;
                    // A fresh tick colliding with a pending one merges into a
                    // single sweep, so one of them is lost.
                    tick_ovf_d  = tick_1hz && tick_pend_q;
                end
            end
            ST_SWEEP: begin
                if (time_q[idx_q] != '0) begin
                    time_d[idx_q] = time_q[idx_q] - TW'(1);
                end
                if (idx_q == c_last) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
                if (tick_1hz) begin
                    if (tick_pend_q) begin
                        tick_ovf_d = 1'b1;
                    end else begin
                        tick_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Commands are only accepted in IDLE, so they never collide with a
        // sweep decrement; a same-cycle tick sweeps the updated value.
        if (w_cmd_hit) begin
            case (cmd_op)
                3'd0, 3'd1, 3'd2, 3'd3:
                    time_d[cmd_ch] = (w_sum > c_t_max_w) ? c_t_max : w_sum[TW-1:0];
                3'd4:    time_d[cmd_ch] = c_ld0;
                3'd5:    time_d[cmd_ch] = c_ld1;
                3'd6:    time_d[cmd_ch] = '0;
                default: time_d[cmd_ch] = time_q[cmd_ch];
            endcase
        end
    end

    always_comb begin
        disp_time_d = '0;
        if ({{(32-CW){1'b0}}, disp_ch} < 32'(N_CH)) begin
            disp_time_d = time_q[disp_ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
            tick_ovf_q  <= 1'b0;
            disp_time_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                time_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tick_pend_q <= tick_pend_d;
            tick_ovf_q  <= tick_ovf_d;
            disp_time_q <= disp_time_d;
            for (int i = 0; i < N_CH; i++) begin
                time_q[i] <= time_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_flags
            assign expired[g]  = (time_q[g] == '0);
            assign low_warn[g] = (time_q[g] != '0) && (time_q[g] <= c_warn);
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/meter_bank.md
METER_BANK -- requirements
Module: meter_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_CH  4  number of independent meter channels (1..16)
  TW  14  width of each time register in seconds
  T_MAX  9999  saturation ceiling for any channel
  AMT0/AMT1/AMT2/AMT3  10/180/200/550  add amounts for cmd 0..3
  LD0/LD1  10/205  load values for cmd 4/5
  WARN  10  low-time warning threshold
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  tick_1hz  in  1  one-cycle pulse, once per second, synchronous to clk
  cmd_valid  in  1  command request
  cmd_ready  out  1  block can accept a command this cycle
  cmd_op  in  3  opcode (see REQ-008)
  cmd_ch  in  clog2(N_CH)  target channel
  disp_ch  in  clog2(N_CH)  channel selected for display
  disp_time  out  TW  registered time of disp_ch
  expired  out  N_CH  per-channel flag, time==0
  low_warn  out  N_CH  per-channel flag, 0 < time <= WARN
  tick_ovf  out  1  one-cycle pulse, a tick was dropped

Function
REQ-003 Block SHALL hold N_CH registers time[i], each TW bits and never above T_MAX.
REQ-004 FSM states: IDLE and SWEEP; reset state IDLE.
REQ-005 cmd_ready SHALL be 1 in IDLE and 0 in SWEEP; a command transfers on a rising edge with cmd_valid=1 and cmd_ready=1.
REQ-006 A transferred command SHALL update time[cmd_ch] at that same edge (zero-cycle latency to the register).
REQ-007 cmd_ch >= N_CH SHALL be accepted and ignored (no state change).
REQ-008 Opcodes: 0..3 add AMT0..AMT3 with saturation at T_MAX; 4 load LD0; 5 load LD1; 6 clear to 0; 7 no-op (accepted).
REQ-009 Add arithmetic SHALL use TW+1 bits internally; result > T_MAX SHALL store T_MAX.
REQ-010 In IDLE, tick_1hz=1 or tick_pend=1 SHALL enter SWEEP with idx=0 on the next edge and clear tick_pend.
REQ-011 tick and accepted command in the same IDLE cycle: command applied at that edge, SWEEP entered at that edge; sweep sees the updated value.
REQ-012 In SWEEP, each cycle SHALL decrement time[idx] by 1 if nonzero (hold at 0), then idx increments; after idx==N_CH-1 the FSM SHALL return to IDLE (sweep lasts exactly N_CH cycles).
REQ-013 tick_1hz during SWEEP SHALL set tick_pend; if tick_pend already set, the tick SHALL be dropped and tick_ovf pulsed for one cycle.
REQ-014 A pending tick SHALL start the next sweep on the cycle after return to IDLE; cmd_ready is 1 for that one IDLE cycle.
REQ-015 disp_time SHALL equal time[disp_ch] as of the previous edge (one-cycle register); disp_ch >= N_CH SHALL show 0.
REQ-016 expired and low_warn SHALL be combinational decodes of current time registers.
REQ-017 Channels not addressed by a command or the current sweep index SHALL hold value.

Reset
REQ-018 rst_n=0 SHALL asynchronously force: all time[i]=0, state=IDLE, idx=0, tick_pend=0, disp_time=0, tick_ovf=0; hence expired=all ones, low_warn=0, cmd_ready=1.
REQ-019 Reset asserted mid-SWEEP SHALL abort the sweep; no partial decrement survives; release SHALL be synchronous-safe (first post-release edge behaves as IDLE).

Verification
REQ-020 Reset, then cmd op=3 ch=1, then op=2 ch=1 -> time[1]=550 then 750; expired[1]=0, others 1; disp_ch=1 shows 750 one cycle later.
REQ-021 Load op=5 ch=0 (205), 20 adds op=3 -> time[0] saturates at 9999, never exceeds.
REQ-022 time[2]=11, two ticks spaced > N_CH cycles -> 10 then 9; low_warn[2]=1 from value 10; channel at 0 stays 0 on ticks.
REQ-023 Tick and op=0 ch=0 (time[0]=5) in same IDLE cycle -> cmd applied (15), sweep yields 14; cmd_ready=0 for exactly 4 cycles (N_CH=4).
REQ-024 Three ticks on consecutive cycles -> first starts sweep, second pends, third dropped with tick_ovf=1 for one cycle; exactly two sweeps total.
REQ-025 rst_n pulsed low at sweep idx=2 with all channels at 100 -> all channels 0, state IDLE, cmd_ready=1 immediately.
